// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register file and its helpers.
//   REG_ADDR_W  : default register address width
//   REG_DATA_W  : default register data width
//   REG_ZERO    : address of the hardwired-zero register
//   clr_state_t : bulk-clear sequencer states
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for decode-stage hazard detection.
// One bit per register marks an issued-but-not-written-back producer.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   idle_i            : clear engine idle; updates and outputs only live here
//   clear_all_i       : drop every pending bit (clear engine entry)
//   wr_en_i/wr_addr_i : writeback, resolves a pending bit
//   iss_en_i/iss_addr_i : issue, marks a destination pending
//   rd_addr_i         : packed read addresses, one per read port
//   rd_pending_o      : per-port hazard flag
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     idle_i,
  input  logic                     clear_all_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_pending_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear is applied before set so that a producer issued in the same cycle
  // as the writeback of an older producer stays pending.
  always_comb begin
    pending_d = pending_q;
    if (clear_all_i) begin
      pending_d = '0;
    end else if (idle_i) begin
      if (wr_en_i) pending_d[wr_addr_i] = 1'b0;
      if (iss_en_i) pending_d[iss_addr_i] = 1'b1;
    end
    pending_d[ZERO_A] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A same-cycle writeback to the read address resolves the hazard because
  // the bypass supplies the data.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rdpend
    logic [ADDR_W-1:0] rdA;
    assign rdA = rd_addr_i[gi*ADDR_W +: ADDR_W];
    assign rd_pending_o[gi] = idle_i && pending_q[rdA] &&
                              !(wr_en_i && (wr_addr_i == rdA));
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file for the pipelined MIPS core.
// NUM_RD combinational read ports with write bypass, one clocked write port,
// hardwired-zero register 0, pending-write scoreboard and a bulk-clear engine.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   rd_addr / rd_data    : packed read addresses / combinational read data
//   rd_pending           : per-port outstanding-producer flag
//   wr_en/wr_addr/wr_data: writeback port
//   iss_en/iss_addr      : issue port, marks destination pending
//   clr_req              : start bulk clear (honoured in IDLE only)
//   clr_busy / clr_done  : clear in progress / one-cycle completion pulse
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] LAST_A = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              idle;
  logic              clrStart;

  assign idle     = (state_q == IDLE);
  assign clrStart = idle && clr_req;

  // Clear sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: register 0 is skipped, so the sweep covers 1..DEPTH-1 and the
  // counter stops at all-ones instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_A) state_d = DONE;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs.
  always_comb begin
    clr_busy = (state_q != IDLE);
    clr_done = (state_q == DONE);
  end

  // Storage. Writeback only lands in IDLE; the clear engine owns the array
  // otherwise. A write on the clr_req edge is still performed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (idle) begin
      if (wr_en && (wr_addr != ZERO_A)) mem_q[wr_addr] <= wr_data;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end
  end

  // Read ports with same-cycle bypass, disabled while the clear is running.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rdA;
    assign rdA = rd_addr[gi*ADDR_W +: ADDR_W];
    always_comb begin
      if (rdA == ZERO_A)
        rd_data[gi*DATA_W +: DATA_W] = '0;
      else if (idle && wr_en && (wr_addr == rdA))
        rd_data[gi*DATA_W +: DATA_W] = wr_data;
      else
        rd_data[gi*DATA_W +: DATA_W] = mem_q[rdA];
    end
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .idle_i       (idle),
    .clear_all_i  (clrStart),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .iss_en_i     (iss_en),
    .iss_addr_i   (iss_addr),
    .rd_addr_i    (rd_addr),
    .rd_pending_o (rd_pending)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb, built with three read ports.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pending;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             iss_en = 1'b0;
  logic [AW-1:0]    iss_addr = '0;
  logic             clr_req = 1'b0;
  logic             clr_busy;
  logic             clr_done;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic          issEn;
    logic [AW-1:0] issAddr;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] expData;
    logic [NR-1:0]    expPend;
  } vecT;

  typedef struct packed {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    pend;
  } expT;

  expT expQ[$];
  vecT vecs[16];

  function automatic vecT mk(logic we, logic [4:0] wa, logic [31:0] wd,
                             logic ie, logic [4:0] ia,
                             logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                             logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                             logic p0, logic p1, logic p2);
    vecT v;
    v.wrEn = we; v.wrAddr = wa; v.wrData = wd;
    v.issEn = ie; v.issAddr = ia;
    v.ra = {a2, a1, a0};
    v.expData = {d2, d1, d0};
    v.expPend = {p2, p1, p0};
    return v;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue the
  // expected combinational outputs for that cycle.
  task automatic applyStimulus(input vecT v);
    expT e;
    @(posedge clk); #1;
    wr_en = v.wrEn; wr_addr = v.wrAddr; wr_data = v.wrData;
    iss_en = v.issEn; iss_addr = v.issAddr;
    rd_addr = v.ra;
    e.data = v.expData;
    e.pend = v.expPend;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    expT e;
    @(negedge clk);
    if (expQ.size() == 0) begin
      compareVal({name, " queue"}, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    for (int p = 0; p < NR; p++) begin
      compareVal($sformatf("%s data%0d", name, p), rd_data[p*DW +: DW], e.data[p*DW +: DW]);
      compareVal($sformatf("%s pend%0d", name, p), {31'd0, rd_pending[p]}, {31'd0, e.pend[p]});
    end
    compareVal({name, " busy"}, {31'd0, clr_busy}, 32'd0);
  endtask

  task automatic sweepZero(input string name);
    for (int a = 0; a < 32; a += 3) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 5'(a), 5'(a + 1), 5'(a + 2), 0, 0, 0, 0, 0, 0));
      checkOutput($sformatf("%s a%0d", name, a));
    end
  endtask

  task automatic idleInputs();
    wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    idleInputs();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  int busyCnt;
  int doneCnt;
  int doneAt;

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0,  5, 0, 1,  0, 0, 0,  0, 0, 0);
    vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0,  5, 0, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF,  0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,  5, 5, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0,  0, 0, 0);
    vecs[3]  = mk(1, 0, 32'h12345678, 1, 0,  0, 0, 5,  0, 0, 32'hDEADBEEF,  0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 7,  7, 0, 0,  0, 0, 0,  0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0,  7, 7, 1,  0, 0, 0,  1, 1, 0);
    vecs[7]  = mk(1, 7, 32'h77, 0, 0,  7, 7, 0,  32'h77, 32'h77, 0,  0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0,  7, 0, 0,  32'h77, 0, 0,  0, 0, 0);
    vecs[9]  = mk(1, 9, 32'h99, 1, 9,  9, 0, 0,  32'h99, 0, 0,  0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0,  9, 0, 0,  32'h99, 0, 0,  1, 0, 0);
    vecs[11] = mk(1, 1, 32'h11, 0, 0,  1, 2, 3,  32'h11, 0, 0,  0, 0, 0);
    vecs[12] = mk(1, 2, 32'h22, 1, 3,  1, 2, 3,  32'h11, 32'h22, 0,  0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0,  1, 3, 9,  32'h11, 0, 32'h99,  0, 1, 1);
    vecs[14] = mk(1, 3, 32'h33, 0, 0,  1, 2, 3,  32'h11, 32'h22, 32'h33,  0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0,  3, 9, 1,  32'h33, 32'h99, 32'h11,  0, 1, 0);

    // Reset state while rst_n is held low.
    rd_addr = {5'd0, 5'd0, 5'd5};
    #2;
    compareVal("reset busy", {31'd0, clr_busy}, 32'd0);
    compareVal("reset done", {31'd0, clr_done}, 32'd0);
    compareVal("reset data", rd_data[31:0], 32'd0);
    compareVal("reset pend", {29'd0, rd_pending}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweepZero("post-reset");

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Bulk clear: preload, mark a pending register, then start the clear
    // together with a write that must still land.
    for (int a = 1; a < 32; a++) writeReg(5'(a), 32'hA5A5A5A5);
    @(posedge clk); #1;
    idleInputs();
    iss_en = 1'b1; iss_addr = 5'd12;
    rd_addr = {5'd12, 5'd31, 5'd17};
    @(negedge clk);
    compareVal("preload r17", rd_data[31:0], 32'hA5A5A5A5);
    compareVal("preload r31", rd_data[63:32], 32'hA5A5A5A5);
    @(posedge clk); #1;
    idleInputs();
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    rd_addr = {5'd9, 5'd12, 5'd4};
    @(negedge clk);
    compareVal("clrreq bypass", rd_data[31:0], 32'h44);
    compareVal("clrreq pend12", {31'd0, rd_pending[1]}, 32'd1);
    compareVal("clrreq busy", {31'd0, clr_busy}, 32'd0);

    busyCnt = 0; doneCnt = 0; doneAt = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      idleInputs();
      rd_addr = {5'd2, 5'd31, 5'd4};
      if (busyCnt == 4) begin
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hBAD;
        iss_en = 1'b1; iss_addr = 5'd2;
        clr_req = 1'b1;
      end
      @(negedge clk);
      if (!clr_busy) break;
      busyCnt++;
      if (clr_done) begin
        doneCnt++;
        doneAt = busyCnt;
      end
      if (busyCnt == 1) compareVal("clr c1 r4", rd_data[31:0], 32'h44);
      if (busyCnt == 5) begin
        compareVal("clr c5 r31", rd_data[63:32], 32'hA5A5A5A5);
        compareVal("clr c5 nobypass", rd_data[95:64], 32'd0);
        compareVal("clr c5 pend", {29'd0, rd_pending}, 32'd0);
      end
    end
    compareVal("clr busy cycles", busyCnt, 32);
    compareVal("clr done pulses", doneCnt, 1);
    compareVal("clr done cycle", doneAt, 32);
    idleInputs();
    sweepZero("post-clear");
    applyStimulus(mk(0, 0, 0, 0, 0,  12, 9, 2,  0, 0, 0,  0, 0, 0));
    checkOutput("post-clear pend");

    // Reset in the middle of a clear.
    writeReg(5'd20, 32'hA5A5A5A5);
    writeReg(5'd3, 32'h33);
    @(posedge clk); #1;
    idleInputs();
    clr_req = 1'b1;
    busyCnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      if (clr_busy) busyCnt++;
      if (busyCnt == 10) break;
    end
    compareVal("midclr reached", busyCnt, 10);
    rst_n = 1'b0;
    #1;
    compareVal("midclr busy", {31'd0, clr_busy}, 32'd0);
    compareVal("midclr done", {31'd0, clr_done}, 32'd0);
    @(posedge clk); #1;
    compareVal("midclr done hold", {31'd0, clr_done}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0,  20, 3, 31,  0, 0, 0,  0, 0, 0));
    checkOutput("midclr regs");

    @(posedge clk); #1;
    clr_req = 1'b1;
    @(posedge clk); #1;
    idleInputs();
    @(negedge clk);
    compareVal("reclr busy", {31'd0, clr_busy}, 32'd1);
    doneCnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (clr_done) doneCnt++;
      if (!clr_busy) break;
    end
    compareVal("reclr done", doneCnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
